// File: rtl/cpu_pkg.sv
// Shared definitions for the pipeline sequencing logic.
package cpu_pkg;

    // Sequencer states: normal issue, bubbling the back end dry, parked.
    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StDrain  = 2'd1,
        StHalted = 2'd2
    } state_e;

    // Architectural zero register; writes to it never create a hazard.
    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int unsigned MDU_LAT_DEF   = 4;
    localparam int unsigned DRAIN_CYC_DEF = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Count up on i_inc, hold at all-ones, clear takes priority.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use and MDU stalls, branch flushes,
// debug halt/drain sequencing and saturating stall/flush counters.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned MDU_LAT   = MDU_LAT_DEF,
    parameter int unsigned DRAIN_CYC = DRAIN_CYC_DEF,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [4:0]       i_rs_d,
    input  logic [4:0]       i_rt_d,
    input  logic             i_re1_d,
    input  logic             i_re2_d,
    input  logic [4:0]       i_ws_ex,
    input  logic             i_we_ex,
    input  logic             i_memread_ex,
    input  logic             i_mdu_start_d,
    input  logic             i_mdu_use_d,
    input  logic             i_branch_taken_ex,
    input  logic             i_halt_req,
    output logic             o_pc_we,
    output logic             o_fd_we,
    output logic             o_fd_flush,
    output logic             o_dex_bubble,
    output logic             o_mdu_busy,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    state_e      r_state;
    logic [3:0]  r_mdu_cnt;
    logic [2:0]  r_drain_cnt;
    logic        r_halted;

    logic        w_load_use;
    logic        w_mdu_busy;
    logic        w_mdu_hazard;
    logic        w_stall;
    logic        w_mdu_issue;
    logic [3:0]  w_mdu_nxt;
    logic [2:0]  w_drain_nxt;
    logic        w_stall_inc;

    assign w_load_use = i_memread_ex && i_we_ex && (i_ws_ex != REG_ZERO) &&
                        ((i_re1_d && (i_rs_d == i_ws_ex)) ||
                         (i_re2_d && (i_rt_d == i_ws_ex)));

    assign w_mdu_busy   = (r_mdu_cnt != 4'd0);
    assign w_mdu_hazard = w_mdu_busy && (i_mdu_start_d || i_mdu_use_d);
    assign w_stall      = w_load_use || w_mdu_hazard;

    assign w_mdu_issue = (r_state == StRun) && i_mdu_start_d && !w_stall &&
                         !i_branch_taken_ex;

    // Next MDU occupancy: load on issue, otherwise run down to zero.
    always_comb begin
        w_mdu_nxt = 4'd0;
        if (w_mdu_issue) begin
            w_mdu_nxt = 4'(MDU_LAT);
        end else if (w_mdu_busy) begin
            w_mdu_nxt = r_mdu_cnt - 4'd1;
        end
    end

    assign w_drain_nxt = (r_drain_cnt == 3'(DRAIN_CYC)) ? r_drain_cnt
                                                        : r_drain_cnt + 3'd1;

    // Pipeline enables; a taken branch wins over every stall source because
    // the decode instruction is on the wrong path.
    always_comb begin
        o_pc_we      = 1'b1;
        o_fd_we      = 1'b1;
        o_fd_flush   = 1'b0;
        o_dex_bubble = 1'b0;
        if (i_branch_taken_ex) begin
            o_fd_flush   = 1'b1;
            o_dex_bubble = 1'b1;
        end else if ((r_state != StRun) || w_stall) begin
            o_pc_we      = 1'b0;
            o_fd_we      = 1'b0;
            o_dex_bubble = 1'b1;
        end
    end

    // MDU busy window counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mdu_cnt <= 4'd0;
        end else begin
            r_mdu_cnt <= w_mdu_nxt;
        end
    end

    // Halt/drain FSM. HALTED is entered on the edge where the drain count and
    // the MDU run-down both complete, so halted rises with the MDU idle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StRun;
            r_drain_cnt <= 3'd0;
            r_halted    <= 1'b0;
        end else begin
            case (r_state)
                StRun: begin
                    if (i_halt_req) begin
                        r_state     <= StDrain;
                        r_drain_cnt <= 3'd0;
                    end
                end
                StDrain: begin
                    if (!i_halt_req) begin
                        r_state <= StRun;
                    end else if (i_branch_taken_ex) begin
                        // New instructions entered behind the branch; restart.
                        r_drain_cnt <= 3'd0;
                    end else begin
                        r_drain_cnt <= w_drain_nxt;
                        if ((w_drain_nxt == 3'(DRAIN_CYC)) && (w_mdu_nxt == 4'd0)) begin
                            r_state  <= StHalted;
                            r_halted <= 1'b1;
                        end
                    end
                end
                StHalted: begin
                    if (!i_halt_req) begin
                        r_state  <= StRun;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= StRun;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign w_stall_inc = (r_state == StRun) && w_stall && !i_branch_taken_ex;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .i_clk (i_clk),
        .i_clr (i_rst),
        .i_inc (w_stall_inc),
        .o_cnt (o_stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .i_clk (i_clk),
        .i_clr (i_rst),
        .i_inc (i_branch_taken_ex),
        .o_cnt (o_flush_cnt)
    );

    assign o_mdu_busy = w_mdu_busy;
    assign o_halted   = r_halted;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// traffic, every cycle compared against a cycle-count reference model.
module tb_hazard_ctrl;

    localparam int unsigned MDU_LAT   = 4;
    localparam int unsigned DRAIN_CYC = 3;
    localparam int unsigned CNT_W     = 4;
    localparam int          CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       rs_d, rt_d, ws_ex;
    logic             re1_d, re2_d, we_ex, memread_ex;
    logic             mdu_start_d, mdu_use_d, branch_taken_ex, halt_req;
    logic             pc_we, fd_we, fd_flush, dex_bubble, mdu_busy, halted;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: 0 = running, 1 = draining, 2 = halted.
    int m_mode;
    int m_mdu_left;
    int m_drained;
    int m_stalls;
    int m_flushes;

    hazard_ctrl #(
        .MDU_LAT   (MDU_LAT),
        .DRAIN_CYC (DRAIN_CYC),
        .CNT_W     (CNT_W)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_rs_d            (rs_d),
        .i_rt_d            (rt_d),
        .i_re1_d           (re1_d),
        .i_re2_d           (re2_d),
        .i_ws_ex           (ws_ex),
        .i_we_ex           (we_ex),
        .i_memread_ex      (memread_ex),
        .i_mdu_start_d     (mdu_start_d),
        .i_mdu_use_d       (mdu_use_d),
        .i_branch_taken_ex (branch_taken_ex),
        .i_halt_req        (halt_req),
        .o_pc_we           (pc_we),
        .o_fd_we           (fd_we),
        .o_fd_flush        (fd_flush),
        .o_dex_bubble      (dex_bubble),
        .o_mdu_busy        (mdu_busy),
        .o_halted          (halted),
        .o_stall_cnt       (stall_cnt),
        .o_flush_cnt       (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode     = 0;
        m_mdu_left = 0;
        m_drained  = 0;
        m_stalls   = 0;
        m_flushes  = 0;
    endtask

    task automatic set_idle();
        rst             = 1'b0;
        rs_d            = 5'd0;
        rt_d            = 5'd0;
        ws_ex           = 5'd0;
        re1_d           = 1'b0;
        re2_d           = 1'b0;
        we_ex           = 1'b0;
        memread_ex      = 1'b0;
        mdu_start_d     = 1'b0;
        mdu_use_d       = 1'b0;
        branch_taken_ex = 1'b0;
    endtask

    // One clock: compare outputs mid-cycle, then advance the model.
    task automatic step();
        bit busy, lu, stall, issue;
        int new_left;
        bit e_pc, e_fd, e_fl, e_bub;
        @(negedge clk);
        busy  = (m_mdu_left > 0);
        lu    = memread_ex && we_ex && (ws_ex != 5'd0) &&
                ((re1_d && rs_d == ws_ex) || (re2_d && rt_d == ws_ex));
        stall = lu || (busy && (mdu_start_d || mdu_use_d));
        if (branch_taken_ex) begin
            e_pc = 1; e_fd = 1; e_fl = 1; e_bub = 1;
        end else if (m_mode != 0 || stall) begin
            e_pc = 0; e_fd = 0; e_fl = 0; e_bub = 1;
        end else begin
            e_pc = 1; e_fd = 1; e_fl = 0; e_bub = 0;
        end
        check_eq("pc_we", 32'(pc_we), 32'(e_pc));
        check_eq("fd_we", 32'(fd_we), 32'(e_fd));
        check_eq("fd_flush", 32'(fd_flush), 32'(e_fl));
        check_eq("dex_bubble", 32'(dex_bubble), 32'(e_bub));
        check_eq("mdu_busy", 32'(mdu_busy), 32'(busy));
        check_eq("halted", 32'(halted), 32'(m_mode == 2));
        check_eq("stall_cnt", 32'(stall_cnt), 32'(m_stalls));
        check_eq("flush_cnt", 32'(flush_cnt), 32'(m_flushes));

        if (rst) begin
            model_reset();
        end else begin
            issue    = (m_mode == 0) && mdu_start_d && !stall && !branch_taken_ex;
            new_left = issue ? int'(MDU_LAT) : (busy ? m_mdu_left - 1 : 0);
            if (m_mode == 0 && stall && !branch_taken_ex && m_stalls < CNT_MAX)
                m_stalls++;
            if (branch_taken_ex && m_flushes < CNT_MAX)
                m_flushes++;
            case (m_mode)
                0: if (halt_req) begin m_mode = 1; m_drained = 0; end
                1: begin
                    if (!halt_req) m_mode = 0;
                    else if (branch_taken_ex) m_drained = 0;
                    else begin
                        if (m_drained < int'(DRAIN_CYC)) m_drained++;
                        if (m_drained >= int'(DRAIN_CYC) && new_left == 0) m_mode = 2;
                    end
                end
                default: if (!halt_req) m_mode = 0;
            endcase
            m_mdu_left = new_left;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        set_idle();
        halt_req = 1'b0;
        rst      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        step();  // reset state

        // Load-use on rs, then the same with the zero register.
        memread_ex = 1; we_ex = 1; ws_ex = 5'd8; rs_d = 5'd8; re1_d = 1;
        step();
        set_idle();
        step();
        memread_ex = 1; we_ex = 1; ws_ex = 5'd0; rs_d = 5'd0; re1_d = 1;
        step();
        set_idle();
        // Load-use on rt.
        memread_ex = 1; we_ex = 1; ws_ex = 5'd3; rt_d = 5'd3; re2_d = 1;
        step();
        set_idle();

        // mult then mfhi: stalled for MDU_LAT cycles.
        mdu_start_d = 1;
        step();
        mdu_start_d = 0; mdu_use_d = 1;
        repeat (MDU_LAT + 2) step();
        set_idle();

        // Branch coinciding with a load-use.
        memread_ex = 1; we_ex = 1; ws_ex = 5'd8; rs_d = 5'd8; re1_d = 1;
        branch_taken_ex = 1;
        step();
        set_idle();

        // Full halt, release, then an aborted halt.
        halt_req = 1;
        repeat (6) step();
        halt_req = 0;
        repeat (2) step();
        halt_req = 1;
        repeat (2) step();
        halt_req = 0;
        repeat (2) step();

        // Halt with the MDU busy.
        mdu_start_d = 1;
        step();
        mdu_start_d = 0; halt_req = 1;
        repeat (7) step();
        halt_req = 0;
        step();

        // Reset while draining with the MDU busy.
        mdu_start_d = 1;
        step();
        mdu_start_d = 0; halt_req = 1;
        repeat (2) step();
        rst = 1; halt_req = 0;
        step();
        rst = 0;
        step();

        // Drive the stall counter into saturation.
        memread_ex = 1; we_ex = 1; ws_ex = 5'd5; rs_d = 5'd5; re1_d = 1;
        repeat (CNT_MAX + 4) step();
        set_idle();
        step();

        // Random traffic over a small register range to provoke matches.
        for (int n = 0; n < 4000; n++) begin
            rs_d            = 5'($urandom_range(0, 3));
            rt_d            = 5'($urandom_range(0, 3));
            ws_ex           = 5'($urandom_range(0, 3));
            re1_d           = 1'($urandom_range(0, 1));
            re2_d           = 1'($urandom_range(0, 1));
            we_ex           = 1'($urandom_range(0, 3) != 0);
            memread_ex      = 1'($urandom_range(0, 2) == 0);
            mdu_start_d     = 1'($urandom_range(0, 5) == 0);
            mdu_use_d       = 1'($urandom_range(0, 5) == 0);
            branch_taken_ex = 1'($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 14) == 0) halt_req = ~halt_req;
            rst             = 1'($urandom_range(0, 399) == 0);
            step();
        end
        set_idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
